// File: rtl/hash_table_pkg.sv
// hash_table: shared hash-table command types and arbiter defaults
//   ht_op_e      - command opcode
//   ht_command_t - one command into the bucket-calc/lookup/insert pipeline
//   HT_N_REQ     - default number of command sources
//   ht_req_id_t  - source index for the default configuration
package hash_table;
    localparam int HT_KEY_W = 16;
    localparam int HT_VAL_W = 16;
    localparam int HT_N_REQ = 4;
    typedef enum logic [1:0] {HT_NOP, HT_LOOKUP, HT_INSERT, HT_DELETE} ht_op_e;
    typedef struct packed {
        ht_op_e              op;
        logic [HT_KEY_W-1:0] key;
        logic [HT_VAL_W-1:0] value;
    } ht_command_t;
    typedef logic [$clog2(HT_N_REQ)-1:0] ht_req_id_t;
endpackage

// File: rtl/ht_rr_pick.sv
// ht_rr_pick: combinational rotate-priority pick, first set request at or after ptr_i
//   req_i     - request vector
//   ptr_i     - highest-priority index this cycle
//   gnt_idx_o - chosen index (0 when none)
//   gnt_any_o - any request set
module ht_rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_any_o
);
    int idx;
    // Scan from the farthest position back to ptr so the nearest request wins last.
    always_comb begin
        gnt_idx_o = '0;
        idx = 0;
        gnt_any_o = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) gnt_idx_o = W'(idx);
        end
    end
endmodule

// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: round-robin, credit-limited arbiter feeding the hash-table command pipeline
//   req_cmd_i/req_valid_i/req_ready_o - per-source command streams
//   cmd_o/cmd_id_o/cmd_valid_o/cmd_ready_i - registered winning command and its source
//   done_valid_i/done_id_i - completion returns one credit to a source
//   busy_o - output valid or any command in flight
//   err_o  - sticky: completion for an unknown source or one with nothing in flight
module ht_cmd_arbiter
    import hash_table::*;
#(
    parameter int N_REQ        = HT_N_REQ,
    parameter int ID_WIDTH     = $clog2(N_REQ),
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  ht_command_t [N_REQ-1:0]  req_cmd_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output ht_command_t              cmd_o,
    output logic [ID_WIDTH-1:0]      cmd_id_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    input  logic                     done_valid_i,
    input  logic [ID_WIDTH-1:0]      done_id_i,
    output logic                     busy_o,
    output logic                     err_o
);
    ht_command_t           cmd_q, cmd_d;
    logic [ID_WIDTH-1:0]   id_q, id_d, ptr_q, ptr_d, gnt;
    logic                  valid_q, valid_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q [N_REQ];
    logic [CNT_WIDTH-1:0]  cnt_d [N_REQ];
    logic [N_REQ-1:0]      elig, inc, dec, nz;
    logic                  gnt_any, load_en, accept, done_bad;
    for (genvar i = 0; i < N_REQ; i++) begin : g_src
        assign nz[i]   = cnt_q[i] != '0;
        assign elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_WIDTH'(MAX_INFLIGHT));
        assign inc[i]  = accept && (gnt == ID_WIDTH'(i));
        assign dec[i]  = done_valid_i && (done_id_i == ID_WIDTH'(i));
    end
    ht_rr_pick #(.N(N_REQ)) u_pick (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt),
        .gnt_any_o (gnt_any)
    );
    assign load_en     = !valid_q || cmd_ready_i;
    assign accept      = load_en && gnt_any;
    assign req_ready_o = accept ? N_REQ'(1) << gnt : '0;
    // No decoded index means the id is out of range; a decoded index with zero count is an underflow.
    assign done_bad    = done_valid_i && (!(|dec) || |(dec & ~nz));
    always_comb begin
        cmd_d   = accept ? req_cmd_i[gnt] : cmd_q;
        id_d    = accept ? gnt : id_q;
        valid_d = load_en ? gnt_any : valid_q;
        ptr_d   = accept ? ((gnt == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt + 1'b1) : ptr_q;
        err_d   = err_q || done_bad;
        for (int i = 0; i < N_REQ; i++)
            cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + 1'b1 :
                       (dec[i] && !inc[i] && nz[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            cmd_q   <= cmd_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign cmd_o       = cmd_q;
    assign cmd_id_o    = id_q;
    assign cmd_valid_o = valid_q;
    assign err_o       = err_q;
    assign busy_o      = valid_q || |nz;
endmodule
